serial_word_feeder: RTL

- Upstream stage of the team's 4-bit bidirectional shift register.
- Accepts a parallel word and a shift direction over a valid/ready handshake.
- Emits the word one bit per clock on the matching serial input, together with direction and a shift enable.
- After exactly WIDTH shifts, the downstream register holds the word bit-exact; a one-cycle done pulse then marks frame completion.

---
 rtl/serial_word_feeder_pkg.sv | 17 +
 rtl/serial_word_feeder_counter.sv | 40 ++++
 rtl/serial_word_feeder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/serial_word_feeder_pkg.sv
// Shared definitions for the serial word feeder and the bidirectional shift
// register it drives: direction encoding, FSM states and default width.
package serial_word_feeder_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Direction encoding shared with the downstream shift register
  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_word_feeder_counter.sv
// Bit-index counter for the feeder: loadable up-counter with enable and clear,
// saturating at WIDTH-1 and flagging that terminal count.
module shift_bit_counter
  import serial_word_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  assign w_tc = (r_cnt == CNT_W'(WIDTH - 1));

  // Increment is gated at terminal count so the index never wraps in a frame
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && !w_tc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = w_tc;

endmodule

// File: rtl/serial_word_feeder.sv
// Serializes a parallel word onto the right/left serial input of a
// bidirectional shift register, one bit per enabled shift, then pulses done.
module serial_word_feeder
  import serial_word_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_dir,
  output logic             load_ready,
  input  logic             hold,
  output logic             shift_en,
  output logic             direction,
  output logic             si_right,
  output logic             si_left,
  output logic             frame_done
);

  state_t           r_state;
  logic [WIDTH-1:0] r_word;
  logic             r_dir;
  logic             r_load_ready;
  logic             r_shift_en;
  logic             r_direction;
  logic             r_si_right;
  logic             r_si_left;
  logic             r_frame_done;

  logic             w_accept;
  logic             w_adv;
  logic [CNT_W-1:0] w_cnt;
  logic [CNT_W-1:0] w_idx_nxt;
  logic             w_tc;

  // Bit k of the frame on the lane that matches the direction; other lane 0.
  // Returned as {left, right}.
  function automatic logic [1:0] lanes(input logic [WIDTH-1:0] word,
                                       input logic dir,
                                       input logic [CNT_W-1:0] k);
    logic [CNT_W-1:0] pos;
    logic             b;
    pos = (dir == DIR_LEFT) ? k : (CNT_W'(WIDTH - 1) - k);
    b   = word[pos];
    return (dir == DIR_LEFT) ? {b, 1'b0} : {1'b0, b};
  endfunction

  assign w_accept  = (r_state == ST_IDLE) && load_valid && r_load_ready;
  assign w_adv     = (r_state == ST_SHIFT) && r_shift_en;
  assign w_idx_nxt = w_cnt + CNT_W'(1);

  shift_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_accept),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (w_adv),
    .o_cnt      (w_cnt),
    .o_tc       (w_tc)
  );

  // hold is sampled at the clock edge and gates the following cycle's shift,
  // keeping every output a flop with no input-to-output path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_word       <= '0;
      r_dir        <= DIR_RIGHT;
      r_load_ready <= 1'b1;
      r_shift_en   <= 1'b0;
      r_direction  <= 1'b0;
      r_si_right   <= 1'b0;
      r_si_left    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_frame_done <= 1'b0;
          if (w_accept) begin
            r_word                   <= load_data;
            r_dir                    <= load_dir;
            r_state                  <= ST_SHIFT;
            r_load_ready             <= 1'b0;
            r_shift_en               <= 1'b1;
            r_direction              <= load_dir;
            {r_si_left, r_si_right}  <= lanes(load_data, load_dir, '0);
          end
        end
        ST_SHIFT: begin
          if (r_shift_en && w_tc) begin
            r_state      <= ST_DONE;
            r_shift_en   <= 1'b0;
            r_direction  <= 1'b0;
            r_si_right   <= 1'b0;
            r_si_left    <= 1'b0;
            r_frame_done <= 1'b1;
          end else if (r_shift_en) begin
            r_shift_en              <= ~hold;
            {r_si_left, r_si_right} <= lanes(r_word, r_dir, w_idx_nxt);
          end else begin
            r_shift_en <= ~hold;
          end
        end
        ST_DONE: begin
          r_frame_done <= 1'b0;
          r_load_ready <= 1'b1;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_load_ready <= 1'b1;
          r_shift_en   <= 1'b0;
          r_direction  <= 1'b0;
          r_si_right   <= 1'b0;
          r_si_left    <= 1'b0;
          r_frame_done <= 1'b0;
        end
      endcase
    end
  end

  assign load_ready = r_load_ready;
  assign shift_en   = r_shift_en;
  assign direction  = r_direction;
  assign si_right   = r_si_right;
  assign si_left    = r_si_left;
  assign frame_done = r_frame_done;

endmodule
